// File: rtl/dma_pcie_cc_arb.sv
// Packet-granular round-robin arbiter for the PCIe completer-completion stream.
// N_SRC sources share one CC port; the output goes through a 2-entry skid slice.
module dma_pcie_cc_arb #(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 81,
    parameter int KEEP_WIDTH = DATA_WIDTH / 32
) (
    input  logic                        user_clk,
    input  logic                        user_reset,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_SRC*USER_WIDTH-1:0] s_tuser,
    input  logic [N_SRC*KEEP_WIDTH-1:0] s_tkeep,
    input  logic [N_SRC-1:0]            s_tlast,
    input  logic [N_SRC-1:0]            s_tvalid,
    output logic [N_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic [USER_WIDTH-1:0]       m_tuser,
    output logic [KEEP_WIDTH-1:0]       m_tkeep,
    output logic                        m_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [N_SRC-1:0]            grant,
    output logic [15:0]                 pkt_cnt
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [N_SRC-1:0]        r_grant;

    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [USER_WIDTH-1:0]   r_out_user;
    logic [KEEP_WIDTH-1:0]   r_out_keep;
    logic                    r_out_last;

    logic                    r_skid_valid;
    logic [DATA_WIDTH-1:0]   r_skid_data;
    logic [USER_WIDTH-1:0]   r_skid_user;
    logic [KEEP_WIDTH-1:0]   r_skid_keep;
    logic                    r_skid_last;

    logic [15:0]             r_pkt_cnt;

    logic [DATA_WIDTH-1:0]   w_src_data [N_SRC];
    logic [USER_WIDTH-1:0]   w_src_user [N_SRC];
    logic [KEEP_WIDTH-1:0]   w_src_keep [N_SRC];

    logic                    w_win_found;
    logic [IDX_W-1:0]        w_win_idx;
    logic [IDX_W-1:0]        w_sel_idx;
    logic                    w_sel_valid;
    logic                    w_int_ready;
    logic                    w_accept;
    logic                    w_out_ready;
    logic [DATA_WIDTH-1:0]   w_in_data;
    logic [USER_WIDTH-1:0]   w_in_user;
    logic [KEEP_WIDTH-1:0]   w_in_keep;
    logic                    w_in_last;

    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_SRC - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign w_src_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_src_user[gi] = s_tuser[gi*USER_WIDTH +: USER_WIDTH];
            assign w_src_keep[gi] = s_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        end
    endgenerate

    // First requesting source at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        int j;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= N_SRC) begin
                j = j - N_SRC;
            end
            if (!w_win_found && s_tvalid[j]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'(j);
            end
        end
    end

    // Reset also closes s_tready so nothing is accepted into state being cleared.
    assign w_int_ready = ~r_skid_valid & ~user_reset;
    assign w_sel_idx   = (r_state == ST_PKT) ? r_grant_idx : w_win_idx;
    assign w_sel_valid = (r_state == ST_PKT) ? s_tvalid[r_grant_idx] : w_win_found;
    assign w_accept    = w_sel_valid & w_int_ready;
    assign w_out_ready = m_tready | ~r_out_valid;

    assign w_in_data = w_src_data[w_sel_idx];
    assign w_in_user = w_src_user[w_sel_idx];
    assign w_in_keep = w_src_keep[w_sel_idx];
    assign w_in_last = s_tlast[w_sel_idx];

    always_comb begin
        s_tready = '0;
        if (w_int_ready && ((r_state == ST_PKT) || w_win_found)) begin
            s_tready[w_sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_in_last) begin
                            r_rr_ptr <= f_inc(w_win_idx);
                        end else begin
                            r_state     <= ST_PKT;
                            r_grant_idx <= w_win_idx;
                            r_grant     <= {{(N_SRC-1){1'b0}}, 1'b1} << w_win_idx;
                        end
                    end
                end
                ST_PKT: begin
                    if (w_accept && w_in_last) begin
                        r_state  <= ST_IDLE;
                        r_grant  <= '0;
                        r_rr_ptr <= f_inc(r_grant_idx);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register feeds the core; skid catches the one beat that slips in on a stall.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_user   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_user  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
            r_pkt_cnt    <= '0;
        end else begin
            if (w_out_ready) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_user   <= r_skid_user;
                    r_out_keep   <= r_skid_keep;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_out_data <= w_in_data;
                        r_out_user <= w_in_user;
                        r_out_keep <= w_in_keep;
                        r_out_last <= w_in_last;
                    end
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_in_data;
                r_skid_user  <= w_in_user;
                r_skid_keep  <= w_in_keep;
                r_skid_last  <= w_in_last;
            end
            if (r_out_valid && m_tready && r_out_last) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign m_tvalid = r_out_valid;
    assign m_tdata  = r_out_data;
    assign m_tuser  = r_out_user;
    assign m_tkeep  = r_out_keep;
    assign m_tlast  = r_out_last;
    assign grant    = r_grant;
    assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_dma_pcie_cc_arb.sv
// Scoreboard bench for dma_pcie_cc_arb: per-source drivers feed queued beats,
// a monitor pops the expected-beat queue on every output handshake.
module tb_dma_pcie_cc_arb;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int KW = DW / 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            user_reset;
    logic [N*DW-1:0] s_tdata;
    logic [N*UW-1:0] s_tuser;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [UW-1:0]   m_tuser;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic [15:0]     pkt_cnt;

    beat_t        src_q [N][$];
    beat_t        exp_q [$];
    logic [N-1:0] hs;
    logic [N-1:0] hold;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    dma_pcie_cc_arb #(
        .N_SRC      (N),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .KEEP_WIDTH (KW)
    ) dut (
        .user_clk   (clk),
        .user_reset (user_reset),
        .s_tdata    (s_tdata),
        .s_tuser    (s_tuser),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tuser    (m_tuser),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .grant      (grant),
        .pkt_cnt    (pkt_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    function automatic beat_t mk(input int src, input int pkt, input int beat, input bit last);
        beat_t b;
        b.data = {8'(src), 8'(pkt), 8'(beat), 40'h5A5AC3C30F};
        b.user = 8'(src * 16 + beat);
        b.keep = KW'(beat + 1);
        b.last = last;
        return b;
    endfunction

    task automatic send_pkt(input int src, input int pkt, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b = mk(src, pkt, k, (k == n - 1));
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
        end
        exp_q.delete();
        hold = '0;
        hs   = '0;
    endtask

    task automatic do_reset();
        tick();
        user_reset = 1'b1;
        m_tready   = 1'b1;
        flush();
        tick();
        tick();
        user_reset = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, 128'(n >= 300), 128'd0);
    endtask

    // Source drivers: advance past a beat once the previous cycle's handshake was seen.
    initial begin
        beat_t tmp;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) begin
                    tmp = src_q[i].pop_front();
                end
                if (src_q[i].size() > 0 && !hold[i]) begin
                    s_tvalid[i]           = 1'b1;
                    s_tdata[i*DW +: DW]   = src_q[i][0].data;
                    s_tuser[i*UW +: UW]   = src_q[i][0].user;
                    s_tkeep[i*KW +: KW]   = src_q[i][0].keep;
                    s_tlast[i]            = src_q[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: inputs are stable at the falling edge, so this is the beat the next edge moves.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            if (!user_reset && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_beat: got unexpected %h with no beat expected", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 128'({m_tdata, m_tuser, m_tkeep, m_tlast}),
                        128'({e.data, e.user, e.keep, e.last}));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before 300000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] rot;
        user_reset = 1'b1;
        m_tready   = 1'b1;
        s_tvalid   = '0;
        s_tdata    = '0;
        s_tuser    = '0;
        s_tkeep    = '0;
        s_tlast    = '0;
        hold       = '0;
        hs         = '0;

        // Reset state, then one 4-beat packet from source 0.
        do_reset();
        @(negedge clk);
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_m_tlast", 128'(m_tlast), 128'd0);
        chk("rst_m_tdata", 128'(m_tdata), 128'd0);
        chk("rst_grant", 128'(grant), 128'd0);
        chk("rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        tick();
        send_pkt(0, 0, 4);
        @(negedge clk);
        chk("t1_s_tready", 128'(s_tready), 128'b001);
        repeat (3) begin
            @(negedge clk);
            chk("t1_grant", 128'(grant), 128'b001);
        end
        @(negedge clk);
        chk("t1_grant_released", 128'(grant), 128'd0);
        wait_done("t1");
        chk("t1_pkt_cnt", 128'(pkt_cnt), 128'd1);

        // Two sources with back-to-back 3-beat packets alternate.
        do_reset();
        tick();
        send_pkt(0, 0, 3);
        send_pkt(1, 0, 3);
        send_pkt(0, 1, 3);
        send_pkt(1, 1, 3);
        wait_done("t2");
        chk("t2_pkt_cnt", 128'(pkt_cnt), 128'd4);

        // Sink stalls for 5 cycles mid-packet.
        do_reset();
        tick();
        send_pkt(0, 0, 8);
        tick();
        tick();
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                chk("t3_s_tready_full", 128'(s_tready), 128'd0);
                chk("t3_m_tvalid_held", 128'(m_tvalid), 128'd1);
                chk("t3_m_tdata_held", 128'(m_tdata), 128'(exp_q[0].data));
            end
            tick();
        end
        m_tready = 1'b1;
        wait_done("t3");
        chk("t3_pkt_cnt", 128'(pkt_cnt), 128'd1);

        // Granted source bubbles for 3 cycles while source 1 waits.
        do_reset();
        tick();
        send_pkt(0, 0, 5);
        send_pkt(1, 0, 2);
        tick();
        tick();
        hold[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_grant_held", 128'(grant), 128'b001);
            chk("t4_s_tready1", 128'(s_tready[1]), 128'd0);
            tick();
        end
        hold[0] = 1'b0;
        wait_done("t4");
        chk("t4_pkt_cnt", 128'(pkt_cnt), 128'd2);

        // Single-beat packets from three sources rotate one per cycle.
        do_reset();
        tick();
        send_pkt(0, 0, 1);
        send_pkt(1, 0, 1);
        send_pkt(2, 0, 1);
        send_pkt(0, 1, 1);
        rot = 3'b001;
        repeat (4) begin
            @(negedge clk);
            chk("t5_s_tready", 128'(s_tready), 128'(rot));
            chk("t5_grant", 128'(grant), 128'd0);
            rot = {rot[N-2:0], rot[N-1]};
        end
        wait_done("t5");
        chk("t5_pkt_cnt", 128'(pkt_cnt), 128'd4);

        // Reset on beat 2 of a packet; rr pointer was 1 beforehand.
        tick();
        send_pkt(0, 0, 4);
        tick();
        user_reset = 1'b1;
        flush();
        tick();
        user_reset = 1'b0;
        @(negedge clk);
        chk("t6_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("t6_grant", 128'(grant), 128'd0);
        chk("t6_pkt_cnt", 128'(pkt_cnt), 128'd0);
        chk("t6_s_tready", 128'(s_tready), 128'd0);
        tick();
        send_pkt(0, 1, 3);
        send_pkt(1, 1, 1);
        wait_done("t6");
        chk("t6_pkt_cnt_after", 128'(pkt_cnt), 128'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_pcie_cc_arb.md
Name: dma_pcie_cc_arb

Overview:
- Shares the single PCIe completer-completion (CC) AXI-stream port of the DMA among N_SRC completion sources, e.g. CSR/BAR completer and bypass MM completer.
- Round-robin arbitration at packet granularity: once a source wins, the grant is locked until that source's tlast beat is accepted.
- The output is fully registered through a 2-entry skid slice, so every ready path is broken toward the PCIe core.
- Sits between the completion generators and the dma_pcie_axis_cc_if master modport to the core.

Parameters:
- N_SRC, 2, number of requesting sources (2..8).
- DATA_WIDTH, 512, CC tdata width.
- USER_WIDTH, 81, CC tuser width.
- KEEP_WIDTH, DATA_WIDTH/32, tkeep width (dword granularity).

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  synchronous, active-high reset.
- s_tdata  in  N_SRC*DATA_WIDTH  per-source data; source i occupies slice i.
- s_tuser  in  N_SRC*USER_WIDTH  per-source tuser.
- s_tkeep  in  N_SRC*KEEP_WIDTH  per-source tkeep.
- s_tlast  in  N_SRC  per-source tlast.
- s_tvalid  in  N_SRC  per-source tvalid.
- s_tready  out  N_SRC  per-source tready.
- m_tdata  out  DATA_WIDTH  to the CC interface.
- m_tuser  out  USER_WIDTH  to the CC interface.
- m_tkeep  out  KEEP_WIDTH  to the CC interface.
- m_tlast  out  1  to the CC interface.
- m_tvalid  out  1  to the CC interface.
- m_tready  in  1  from the CC interface.
- grant  out  N_SRC  one-hot; the currently locked source, zero when idle.
- pkt_cnt  out  16  count of packets delivered on the m side; wraps.

Behaviour:
- Interface: single clock user_clk; reset user_reset is synchronous and active-high.
- Reset values:
  - m_tvalid=0, m_tlast=0, grant=0, s_tready=0, pkt_cnt=0, rr_ptr=0, state=IDLE, skid empty.
  - m_tdata, m_tuser and m_tkeep are reset to 0.
- Skid slice:
  - Two entries: an output register and a skid register.
  - int_ready = ~skid_valid.
  - A beat accepted while the output register is valid and m_tready=0 goes to the skid register.
  - When the output register drains, the skid register moves into it.
  - Latency from source acceptance to m_tvalid is exactly 1 cycle.
  - Throughput is 1 beat per cycle while m_tready=1.
- State machine:
  - IDLE:
    - Winner = first source with s_tvalid=1, searching from rr_ptr upward modulo N_SRC.
    - If a winner exists and int_ready=1, the winner's first beat is accepted in the same cycle (s_tready[winner]=1) and grant is set to the winner's one-hot from the next cycle.
    - If that beat has tlast=1 (single-beat packet), stay in IDLE, leave grant=0 and set rr_ptr=winner+1.
    - Otherwise go to PKT.
  - PKT:
    - s_tready[granted]=int_ready; every other s_tready is 0.
    - The granted source's s_tvalid=0 inserts a bubble; the grant is held.
    - When the granted source's beat is accepted with s_tlast=1: go to IDLE, grant<=0, rr_ptr<=(granted+1) mod N_SRC.
- s_tready is 0 for non-granted sources at all times. s_tready is 0 for every source while int_ready=0.
- Fairness: with all sources continuously requesting, packets interleave 0,1,...,N_SRC-1,0,...
- Stalled sources: a source that deasserts tvalid mid-packet never loses the grant; no timeout.
- pkt_cnt increments on m_tvalid & m_tready & m_tlast; 16-bit wrap from 0xFFFF to 0.
- Stability: m_* outputs stay stable while m_tvalid=1 and m_tready=0 (AXI-stream rule).
- Reset mid-packet: everything returns to reset values in the next cycle and any in-flight or skid beats are discarded. Upstream sources must also be reset.
- Simultaneous events in IDLE: a new request arriving in the same cycle as the previous packet's tlast is arbitrated in the next cycle, so there is a minimum of one IDLE cycle after a multi-beat packet.

Test Plan:
- Single source 0, 4-beat packet, m_tready=1 -> m_tvalid high for cycles 1..4 after the first accept, m_tlast on beat 4, grant=0b01 during beats 2-4, pkt_cnt=1.
- Sources 0 and 1 each continuously sending 3-beat packets -> output order src0,src1,src0,src1; no beats interleaved within a packet; pkt_cnt=4 after 4 packets.
- m_tready low for 5 cycles mid-packet -> at most 2 beats buffered, s_tready[granted]=0 once the skid is full, no beat lost or duplicated, data order preserved.
- Granted source drops tvalid for 3 cycles mid-packet while source 1 is valid -> s_tready[1] stays 0, grant is unchanged, packet completes intact.
- Single-beat packets from 3 sources (N_SRC=3) with all valid -> grants rotate 0,1,2,0; grant stays 0; one packet is accepted per cycle when m_tready=1.
- user_reset asserted on beat 2 of a 4-beat packet -> next cycle m_tvalid=0, grant=0, pkt_cnt=0, rr_ptr=0; a fresh packet after reset goes out correctly.
